// File: rtl/trail_collision_reader.sv
// trail_collision_reader
// Once per frame tick during play, works out each light cycle's next cell,
// reads that cell's frame-buffer word through a port shared with the trail
// writer, and reports sticky per-cycle collision flags.
module trail_collision_reader #(
   parameter int GRID_W      = 224,
   parameter int GRID_H      = 224,
   parameter int CELL_STRIDE = 2,
   parameter int ROW_STRIDE  = 1280,
   parameter int RD_LAT      = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic [2:0]  Game_State,
   input  logic [7:0]  Blue_X,
   input  logic [7:0]  Blue_Y,
   input  logic [7:0]  Red_X,
   input  logic [7:0]  Red_Y,
   input  logic [1:0]  Blue_dir,
   input  logic [1:0]  Red_dir,
   input  logic        mem_busy,
   output logic        rd_req,
   output logic [19:0] rd_addr,
   input  logic [15:0] rd_data,
   output logic        collision_blue,
   output logic        collision_red,
   output logic        check_done
);

   localparam logic [2:0] PLAY = 3'b010;

   typedef enum logic [2:0] {
      IDLE, CALC, REQ_B, WAIT_B, REQ_R, WAIT_R, RESOLVE
   } state_t;

   // Cell coordinates carry a sign bit so a step off the left/top edge is
   // visible as a negative value instead of wrapping to 255.
   typedef struct packed {
      logic signed [8:0] x;
      logic signed [8:0] y;
   } cell_t;

   function automatic cell_t head_cell(input logic [7:0] x, input logic [7:0] y);
      cell_t c;
      c.x = $signed({1'b0, x});
      c.y = $signed({1'b0, y});
      return c;
   endfunction

   function automatic cell_t look_ahead(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] dir);
      cell_t c;
      c = head_cell(x, y);
      case (dir)
         2'b00:   c.y = c.y - 9'sd1;
         2'b01:   c.y = c.y + 9'sd1;
         2'b10:   c.x = c.x - 9'sd1;
         default: c.x = c.x + 9'sd1;
      endcase
      return c;
   endfunction

   function automatic logic is_oob(input cell_t c);
      return c.x[8] || c.y[8] || (int'(c.x) >= GRID_W) || (int'(c.y) >= GRID_H);
   endfunction

   // Address is formed wider than the port and then truncated, so the
   // stride products can never overflow before the final cut.
   function automatic logic [19:0] cell_addr(input cell_t c);
      logic [23:0] full;
      full = 24'($unsigned(c.x)) * 24'(CELL_STRIDE)
           + 24'($unsigned(c.y)) * 24'(ROW_STRIDE);
      return full[19:0];
   endfunction

   state_t      state_q, state_d;
   logic        frame_q, frame_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [19:0] addr_b_q, addr_b_d, addr_r_q, addr_r_d;
   logic        oob_b_q, oob_b_d, oob_r_q, oob_r_d;
   logic        head_on_q, head_on_d;
   logic        occ_b_q, occ_b_d, occ_r_q, occ_r_d;
   logic        col_b_q, col_b_d, col_r_q, col_r_d;
   logic        done_q, done_d;

   logic        playing, tick;
   cell_t       la_b, la_r, hd_b, hd_r;

   assign playing = (Game_State == PLAY);
   assign tick    = frame_clk & ~frame_q;
   assign la_b    = look_ahead(Blue_X, Blue_Y, Blue_dir);
   assign la_r    = look_ahead(Red_X, Red_Y, Red_dir);
   assign hd_b    = head_cell(Blue_X, Blue_Y);
   assign hd_r    = head_cell(Red_X, Red_Y);

   assign collision_blue = col_b_q;
   assign collision_red  = col_r_q;
   assign check_done     = done_q;

   // Next-state and request logic; leaving play overrides every state.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      frame_d   = frame_clk;
      cnt_d     = cnt_q;
      addr_b_d  = addr_b_q;
      addr_r_d  = addr_r_q;
      oob_b_d   = oob_b_q;
      oob_r_d   = oob_r_q;
      head_on_d = head_on_q;
      occ_b_d   = occ_b_q;
      occ_r_d   = occ_r_q;
      col_b_d   = col_b_q;
      col_r_d   = col_r_q;
      done_d    = 1'b0;
      rd_req    = 1'b0;

      if (!playing) begin
         state_d = IDLE;
         col_b_d = 1'b0;
         col_r_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tick) state_d = CALC;
            end
            CALC: begin
               oob_b_d   = is_oob(la_b);
               oob_r_d   = is_oob(la_r);
               addr_b_d  = cell_addr(la_b);
               addr_r_d  = cell_addr(la_r);
               head_on_d = (la_b == la_r) || ((la_b == hd_r) && (la_r == hd_b));
               occ_b_d   = 1'b0;
               occ_r_d   = 1'b0;
               if (!is_oob(la_b))      state_d = REQ_B;
               else if (!is_oob(la_r)) state_d = REQ_R;
               else                    state_d = RESOLVE;
            end
            REQ_B: begin
               if (!mem_busy) begin
                  rd_req  = 1'b1;
                  cnt_d   = 3'(RD_LAT - 1);
                  state_d = WAIT_B;
               end
            end
            WAIT_B: begin
               if (cnt_q == 3'd0) begin
                  occ_b_d = |rd_data;
                  state_d = oob_r_q ? RESOLVE : REQ_R;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            REQ_R: begin
               if (!mem_busy) begin
                  rd_req  = 1'b1;
                  cnt_d   = 3'(RD_LAT - 1);
                  state_d = WAIT_R;
               end
            end
            WAIT_R: begin
               if (cnt_q == 3'd0) begin
                  occ_r_d = |rd_data;
                  state_d = RESOLVE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            RESOLVE: begin
               col_b_d = col_b_q | oob_b_q | occ_b_q | head_on_q;
               col_r_d = col_r_q | oob_r_q | occ_r_q | head_on_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Read address follows whichever cycle's read is in flight.
   always_comb begin
      rd_addr = 20'd0;
      case (state_q)
         REQ_B, WAIT_B: rd_addr = addr_b_q;
         REQ_R, WAIT_R: rd_addr = addr_r_q;
         default:       rd_addr = 20'd0;
      endcase
   end

   // State register; every flop clears asynchronously so reset is immediate.
   always_ff @(posedge Clk or negedge Reset_n) begin
      // NOTE: datapath registers are reset too, so stale addresses never leak after reset.
      if (!Reset_n) begin
         state_q   <= IDLE;
         frame_q   <= 1'b0;
         cnt_q     <= 3'd0;
         addr_b_q  <= 20'd0;
         addr_r_q  <= 20'd0;
         oob_b_q   <= 1'b0;
         oob_r_q   <= 1'b0;
         head_on_q <= 1'b0;
         occ_b_q   <= 1'b0;
         occ_r_q   <= 1'b0;
         col_b_q   <= 1'b0;
         col_r_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         state_q   <= state_d;
         frame_q   <= frame_d;
         cnt_q     <= cnt_d;
         addr_b_q  <= addr_b_d;
         addr_r_q  <= addr_r_d;
         oob_b_q   <= oob_b_d;
         oob_r_q   <= oob_r_d;
         head_on_q <= head_on_d;
         occ_b_q   <= occ_b_d;
         occ_r_q   <= occ_r_d;
         col_b_q   <= col_b_d;
         col_r_q   <= col_r_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Bench for trail_collision_reader: a frame-level model predicts which reads
// are issued on which cycle, when check_done pulses and what the sticky flags
// hold; one negedge process compares the DUT against it every cycle.
module tb_trail_collision_reader;

   localparam int L = 2;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_clk = 1'b0;
   logic [2:0]  Game_State = 3'b010;
   logic [7:0]  Blue_X = 8'd0, Blue_Y = 8'd0, Red_X = 8'd0, Red_Y = 8'd0;
   logic [1:0]  Blue_dir = 2'd0, Red_dir = 2'd0;
   logic        mem_busy = 1'b0;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic [15:0] rd_data = 16'd0;
   logic        collision_blue, collision_red, check_done;

   trail_collision_reader #(.RD_LAT(L)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Game_State(Game_State),
      .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
      .Blue_dir(Blue_dir), .Red_dir(Red_dir), .mem_busy(mem_busy),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .collision_blue(collision_blue), .collision_red(collision_red),
      .check_done(check_done)
   );

   always #10 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model state ----------------
   typedef struct { int cyc; logic [19:0] addr; } req_t;
   typedef struct { int cyc; logic cb; logic cr; } flag_t;

   req_t        exp_req[$];
   flag_t       flag_q[$];
   logic        exp_cb = 1'b0, exp_cr = 1'b0;
   logic        model_cb = 1'b0, model_cr = 1'b0;
   int          exp_done = -1;
   bit          busy_at[int];
   logic [15:0] resp[int];
   logic [15:0] mem[int];
   logic [19:0] obs_addr[$];
   int          obs_done_cyc = -1;
   int          obs_done_cnt = 0;

   function automatic logic [15:0] mem_word(input logic [19:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000;
   endfunction

   function automatic void look(input int x, input int y, input int d,
                                output int lx, output int ly);
      lx = x; ly = y;
      case (d)
         0:       ly = y - 1;
         1:       ly = y + 1;
         2:       lx = x - 1;
         default: lx = x + 1;
      endcase
   endfunction

   function automatic bit oob(input int lx, input int ly);
      return (lx < 0) || (ly < 0) || (lx >= 224) || (ly >= 224);
   endfunction

   function automatic logic [19:0] cell_addr(input int lx, input int ly);
      return 20'(lx * 2 + ly * 1280);
   endfunction

   // Background drivers: writer-busy pattern and the frame-buffer read port
   // (garbage on every cycle that is not a valid response slot).
   initial forever begin
      @(posedge Clk);
      #1;
      mem_busy = busy_at.exists(cyc) ? busy_at[cyc] : 1'b0;
      rd_data  = resp.exists(cyc) ? resp[cyc] : 16'($urandom_range(1, 65535));
   end

   // Compare process: every cycle out of reset.
   initial forever begin
      logic exp_r;
      @(negedge Clk);
      if (Reset_n) begin
         while (flag_q.size() > 0 && flag_q[0].cyc <= cyc) begin
            exp_cb = flag_q[0].cb;
            exp_cr = flag_q[0].cr;
            void'(flag_q.pop_front());
         end
         exp_r = (exp_req.size() > 0 && exp_req[0].cyc == cyc);
         check("rd_req", rd_req, exp_r);
         if (rd_req === 1'b1) begin
            obs_addr.push_back(rd_addr);
            if (mem_busy === 1'b0) resp[cyc + L] = mem_word(rd_addr);
         end
         if (exp_r) check("rd_addr", rd_addr, exp_req[0].addr);
         while (exp_req.size() > 0 && exp_req[0].cyc <= cyc) void'(exp_req.pop_front());
         check("rd_req_while_busy", rd_req & mem_busy, 1'b0);
         check("check_done", check_done, (cyc == exp_done));
         if (check_done === 1'b1) begin
            obs_done_cyc = cyc;
            obs_done_cnt++;
         end
         check("collision_blue", collision_blue, exp_cb);
         check("collision_red", collision_red, exp_cr);
      end
   end

   // Raise frame_clk and predict the whole frame from the rules.
   task automatic start_frame(input int bx, input int by, input int bd,
                              input int rx, input int ry, input int rdr,
                              input int busy_pct, input int busy_off, input int busy_len,
                              output int t, output int done);
      int blx, bly, rlx, rly, c;
      bit ob, orr, hit_b, hit_r, head_on;
      logic [19:0] ab, ar;
      @(posedge Clk);
      #2;
      t = cyc;
      Blue_X = 8'(bx); Blue_Y = 8'(by); Blue_dir = 2'(bd);
      Red_X = 8'(rx);  Red_Y = 8'(ry);  Red_dir = 2'(rdr);
      frame_clk = 1'b1;
      obs_addr.delete();
      obs_done_cyc = -1;
      for (int k = t + 1; k <= t + 40; k++) busy_at[k] = ($urandom_range(0, 99) < busy_pct);
      for (int k = 0; k < busy_len; k++) busy_at[t + busy_off + k] = 1'b1;

      look(bx, by, bd, blx, bly);
      look(rx, ry, rdr, rlx, rly);
      ob  = oob(blx, bly);
      orr = oob(rlx, rly);
      ab  = cell_addr(blx, bly);
      ar  = cell_addr(rlx, rly);
      head_on = (blx == rlx && bly == rly) ||
                (blx == rx && bly == ry && rlx == bx && rly == by);
      hit_b = ob  || (mem_word(ab) != 16'h0) || head_on;
      hit_r = orr || (mem_word(ar) != 16'h0) || head_on;

      // Reads go out in order, each at the first writer-free cycle allowed.
      c = t + 2;
      if (!ob) begin
         while (busy_at.exists(c) && busy_at[c]) c++;
         exp_req.push_back('{c, ab});
         c = c + L + 1;
      end
      if (!orr) begin
         while (busy_at.exists(c) && busy_at[c]) c++;
         exp_req.push_back('{c, ar});
         c = c + L + 1;
      end
      done = c + 1;
      exp_done = done;
      model_cb = model_cb | hit_b;
      model_cr = model_cr | hit_r;
      flag_q.push_back('{done, model_cb, model_cr});
   endtask

   task automatic finish_frame(input int done);
      while (cyc < done + 2) @(posedge Clk);
      #2;
      frame_clk = 1'b0;
   endtask

   task automatic run_frame(input int bx, input int by, input int bd,
                            input int rx, input int ry, input int rdr,
                            input int busy_pct, input int busy_off, input int busy_len,
                            output int t);
      int done;
      start_frame(bx, by, bd, rx, ry, rdr, busy_pct, busy_off, busy_len, t, done);
      finish_frame(done);
   endtask

   // One non-play cycle clears the sticky flags on the next edge.
   task automatic clear_flags();
      @(posedge Clk);
      #2;
      Game_State = 3'b000;
      model_cb = 1'b0;
      model_cr = 1'b0;
      flag_q.push_back('{cyc + 1, 1'b0, 1'b0});
      @(posedge Clk);
      #2;
      Game_State = 3'b010;
   endtask

   function automatic int rand_coord();
      case ($urandom_range(0, 7))
         0:       return 0;
         1:       return 223;
         2:       return 1;
         3:       return 222;
         default: return int'($urandom_range(0, 223));
      endcase
   endfunction

   task automatic seed_cell(input int x, input int y, input int d);
      int lx, ly;
      look(x, y, d, lx, ly);
      if (!oob(lx, ly))
         mem[int'(cell_addr(lx, ly))] = ($urandom_range(0, 2) == 0) ?
                                        16'($urandom_range(1, 65535)) : 16'h0000;
   endtask

   initial begin
      int t, done, cnt_before;
      int bx, by, bd, rx, ry, rdr;

      // Reset state
      repeat (3) @(posedge Clk);
      #2;
      check("reset_rd_req", rd_req, 1'b0);
      check("reset_rd_addr", rd_addr, 20'd0);
      check("reset_collision_blue", collision_blue, 1'b0);
      check("reset_collision_red", collision_red, 1'b0);
      check("reset_check_done", check_done, 1'b0);
      Reset_n = 1'b1;
      repeat (2) @(posedge Clk);

      // Clear path
      run_frame(10, 10, 3, 50, 50, 0, 0, 0, 0, t);
      check("clear_nreq", obs_addr.size(), 2);
      if (obs_addr.size() >= 2) begin
         check("clear_addr_blue", obs_addr[0], 20'd12822);
         check("clear_addr_red", obs_addr[1], 20'd62820);
      end
      check("clear_latency", obs_done_cyc - t, 9);
      check("clear_flags", {collision_blue, collision_red}, 2'b00);

      // Trail hit on red's cell only
      mem[62820] = 16'h0F00;
      run_frame(10, 10, 3, 50, 50, 0, 0, 0, 0, t);
      check("trail_flags", {collision_blue, collision_red}, 2'b01);
      mem.delete(62820);
      clear_flags();

      // Both into the wall
      run_frame(0, 5, 2, 223, 7, 3, 0, 0, 0, t);
      check("wall_nreq", obs_addr.size(), 0);
      check("wall_latency", obs_done_cyc - t, 3);
      check("wall_flags", {collision_blue, collision_red}, 2'b11);
      clear_flags();

      // Head-on into the same cell
      run_frame(20, 20, 3, 22, 20, 2, 0, 0, 0, t);
      check("headon_flags", {collision_blue, collision_red}, 2'b11);
      if (obs_addr.size() >= 1) check("headon_addr", obs_addr[0], 20'd25642);
      clear_flags();

      // Writer owns the port for the first 4 cycles of REQ_B
      run_frame(10, 10, 3, 50, 50, 0, 0, 2, 4, t);
      check("arb_latency", obs_done_cyc - t, 13);
      check("arb_flags", {collision_blue, collision_red}, 2'b00);

      // Abort during WAIT_B after flags were set
      run_frame(0, 5, 2, 223, 7, 3, 0, 0, 0, t);
      cnt_before = obs_done_cnt;
      start_frame(10, 10, 3, 50, 50, 0, 0, 0, 0, t, done);
      while (cyc < t + 3) @(posedge Clk);
      #2;
      Game_State = 3'b000;
      while (exp_req.size() > 0 && exp_req[$].cyc > cyc) void'(exp_req.pop_back());
      if (flag_q.size() > 0 && flag_q[$].cyc > cyc) void'(flag_q.pop_back());
      flag_q.push_back('{cyc + 1, 1'b0, 1'b0});
      model_cb = 1'b0;
      model_cr = 1'b0;
      exp_done = -1;
      @(posedge Clk);
      #2;
      Game_State = 3'b010;
      repeat (12) @(posedge Clk);
      #2;
      frame_clk = 1'b0;
      check("abort_no_done", obs_done_cnt, cnt_before);
      check("abort_flags", {collision_blue, collision_red}, 2'b00);

      // Asynchronous reset while red's read is being requested
      run_frame(0, 5, 2, 223, 7, 3, 0, 0, 0, t);
      start_frame(10, 10, 3, 50, 50, 0, 0, 0, 0, t, done);
      while (cyc < t + 5) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      exp_req.delete();
      flag_q.delete();
      exp_done = -1;
      model_cb = 1'b0; model_cr = 1'b0;
      exp_cb = 1'b0;   exp_cr = 1'b0;
      frame_clk = 1'b0;
      #1;
      check("rst_rd_req", rd_req, 1'b0);
      check("rst_rd_addr", rd_addr, 20'd0);
      check("rst_flags", {collision_blue, collision_red}, 2'b00);
      check("rst_check_done", check_done, 1'b0);
      repeat (2) @(posedge Clk);
      #2;
      Reset_n = 1'b1;
      mem[62820] = 16'h0F00;
      run_frame(10, 10, 3, 50, 50, 0, 0, 0, 0, t);
      check("post_reset_latency", obs_done_cyc - t, 9);
      check("post_reset_flags", {collision_blue, collision_red}, 2'b01);
      mem.delete(62820);

      // Randomized frames
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 1) clear_flags();
         bx = rand_coord(); by = rand_coord(); bd = int'($urandom_range(0, 3));
         rx = rand_coord(); ry = rand_coord(); rdr = int'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: begin
               by = int'($urandom_range(0, 223)); bx = int'($urandom_range(0, 221));
               rx = bx + 2; ry = by; bd = 3; rdr = 2;
            end
            1: begin
               by = int'($urandom_range(0, 223)); bx = int'($urandom_range(0, 222));
               rx = bx + 1; ry = by; bd = 3; rdr = 2;
            end
            default: ;
         endcase
         seed_cell(bx, by, bd);
         seed_cell(rx, ry, rdr);
         run_frame(bx, by, bd, rx, ry, rdr, int'($urandom_range(0, 40)), 0, 0, t);
      end

      repeat (3) @(posedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not end, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/trail_collision_reader.md
# trail_collision_reader

Reads back the trail frame buffer that the trail writer fills, once per frame, to decide whether either light cycle is about to crash. On each rising edge of frame_clk during play, it computes each cycle's look-ahead cell from its position and direction. It checks bounds, fetches the look-ahead word from the frame buffer through a latency-tolerant read port that yields to the writer, and reports per-cycle collision flags to the game-state FSM.

## Interface
Parameters:
- GRID_W, 224: playfield width in cells; valid X is 0..GRID_W-1.
- GRID_H, 224: playfield height in cells; valid Y is 0..GRID_H-1.
- CELL_STRIDE, 2: frame-buffer words per cell step in X.
- ROW_STRIDE, 1280: frame-buffer words per cell step in Y.
- RD_LAT, 2: cycles from an accepted rd_req to valid rd_data (1..4).

Ports:
- Clk, in, 1: 50 MHz system clock. This is the only clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_clk, in, 1: frame tick (~60 Hz), synchronous to Clk, level signal.
- Game_State, in, 3: 3'b010 = play. All other values mean not playing.
- Blue_X, Blue_Y, Red_X, Red_Y, in, 8 each: current head cells.
- Blue_dir, Red_dir, in, 2 each: 00 up, 01 down, 10 left, 11 right.
- mem_busy, in, 1: the writer owns the frame-buffer port this cycle (its we).
- rd_req, out, 1: read request, one cycle per word.
- rd_addr, out, 20: read word address.
- rd_data, in, 16: read data, valid exactly RD_LAT cycles after an accepted rd_req.
- collision_blue, collision_red, out, 1 each: registered collision flags.
- check_done, out, 1: one-cycle pulse when a frame's check has resolved.

## Operation
- Edge detect: register frame_clk. A tick is when frame_clk is 1 now and was 0 in the previous cycle. A tick is acted on only when Game_State == 3'b010 and the FSM is in IDLE. Ticks that arrive while a check is in progress are dropped.
- Look-ahead: 9-bit signed arithmetic.
  - up: Y-1. down: Y+1. left: X-1. right: X+1.
  - The cell is out of bounds (OOB) if any coordinate is < 0, X >= GRID_W, or Y >= GRID_H. There is no wrap-around.
- Address: rd_addr = LX*CELL_STRIDE + LY*ROW_STRIDE. Compute at ≥21 bits, then truncate to 20.
- Occupied: rd_data != 16'h0000.
- FSM states: IDLE, CALC, REQ_B, WAIT_B, REQ_R, WAIT_R, RESOLVE.
  - IDLE → CALC on a valid tick. CALC latches the inputs and computes both look-ahead cells, OOB flags, and addresses.
  - CALC → REQ_B. If blue is OOB, skip to REQ_R; if red is also OOB, skip to RESOLVE.
  - REQ_B: assert rd_req with the blue address only while mem_busy == 0. While mem_busy is 1, stall with rd_req low. An accepted request goes to WAIT_B.
  - WAIT_B: count RD_LAT cycles, then capture occ_b. Next state is REQ_R, or RESOLVE if red is OOB.
  - REQ_R and WAIT_R: same as REQ_B and WAIT_B, for red.
  - RESOLVE: compute the flags and pulse check_done, then go to IDLE.
- Resolution rules:
  - blue_hit = OOB_b | occ_b | head_on.
  - red_hit = OOB_r | occ_r | head_on.
  - head_on: the look-ahead cells are equal, or each cycle's look-ahead equals the other cycle's current head.
- Flags are sticky. RESOLVE ORs the hits into collision_blue and collision_red.
- Abort: if Game_State != 3'b010 in any cycle, the FSM returns to IDLE and both flags clear on the next edge. check_done does not pulse, and any outstanding read data is ignored.
- Reset mid-operation: everything returns immediately to IDLE or zero. rd_data that arrives after reset is ignored.

## Timing
- Reset values: rd_req = 0, rd_addr = 0, collision_blue = 0, collision_red = 0, check_done = 0, FSM = IDLE.
- Tick to CALC: 1 cycle after the frame_clk rising edge is registered.
- No stall, both cells in bounds: check_done asserts 5 + 2*RD_LAT cycles after the tick cycle. That is 9 cycles at RD_LAT = 2.
- Both cycles OOB: check_done asserts 3 cycles after the tick, with no rd_req.
- Each cycle of mem_busy during a REQ state adds exactly 1 cycle of latency.
- rd_addr is held stable for the whole REQ state. rd_req is never high while mem_busy is high.
- Flags update in the same cycle that check_done is high and remain valid until the next RESOLVE or abort.

## Test plan
- Clear path: Game_State = 010, Blue (10,10) right, Red (50,50) up, rd_data = 0. Tick → rd_addr 11*2+10*1280 = 12822, then 50*2+49*1280 = 62820. check_done 9 cycles after the tick; both flags stay 0.
- Trail hit: same setup, but return rd_data = 16'h0F00 for the red read only. Required: collision_red = 1 and collision_blue = 0.
- Wall: Blue (0,5) left, Red (223,7) right. Required: no rd_req, check_done 3 cycles after the tick, both flags = 1.
- Head-on: Blue (20,20) right, Red (22,20) left, both look-ahead cells are (21,20), rd_data = 0. Required: both flags = 1.
- Arbitration: hold mem_busy high for 4 cycles entering REQ_B. Required: rd_req low throughout, check_done delayed by exactly 4 cycles.
- Abort and reset: drop Game_State to 000 during WAIT_B. Required: FSM in IDLE, no check_done, flags cleared. Then pulse Reset_n low mid-REQ_R. Required: all outputs 0 asynchronously.
